stopwatch_core: RTL and testbench

//  Parametrised stopwatch timing core: prescales clk to a centisecond tick and counts
//  MM:SS.cc in packed BCD, with start/stop, pause, lap-hold and clear control.

---
 rtl/stopwatch_core.sv | 150 +++++++++++++++
 tb/tb_stopwatch_core.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// Stopwatch timing core: centisecond prescaler plus MM:SS.cc packed-BCD counter
// with start/stop, pause, lap-hold and clear control.
module stopwatch_core #(
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned DIV_W    = 17,
    parameter int unsigned MAX_MIN  = 59
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    output logic [23:0] disp_bcd,
    output logic        running,
    output logic        lap_hold,
    output logic        overflow,
    output logic        cs_tick
);

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [3:0]       MAX_M10    = 4'(MAX_MIN / 10);
    localparam logic [3:0]       MAX_M1     = 4'(MAX_MIN % 10);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } state_t;

    // Digit order: [5]=m10 [4]=m1 [3]=s10 [2]=s1 [1]=c10 [0]=c1
    state_t              state, state_n;
    logic [DIV_W-1:0]    presc, presc_n;
    logic [5:0][3:0]     count, count_n;
    logic [5:0][3:0]     count_inc;
    logic                count_wrap;
    logic                carry;
    logic [23:0]         disp_n;
    logic                running_n;
    logic                hold_n;
    logic                ovf_n;
    logic                tick_n;
    logic                clear_eff;

    // BCD increment of the count with one-cycle ripple carry and wrap detect
    always_comb begin
        count_inc  = count;
        count_wrap = 1'b0;
        carry      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (count[i] == ((i == 3) ? 4'd5 : 4'd9)) begin
                    count_inc[i] = 4'd0;
                end else begin
                    count_inc[i] = count[i] + 4'd1;
                    carry        = 1'b0;
                end
            end
        end
        if (carry) begin
            if (count[5] == MAX_M10 && count[4] == MAX_M1) begin
                count_inc[5] = 4'd0;
                count_inc[4] = 4'd0;
                count_wrap   = 1'b1;
            end else if (count[4] == 4'd9) begin
                count_inc[4] = 4'd0;
                count_inc[5] = count[5] + 4'd1;
            end else begin
                count_inc[4] = count[4] + 4'd1;
            end
        end
    end

    // Next-state and next-output logic; clear beats start_stop beats lap
    always_comb begin
        state_n   = state;
        presc_n   = presc;
        count_n   = count;
        hold_n    = lap_hold;
        ovf_n     = overflow;
        tick_n    = 1'b0;
        clear_eff = clear && (state != RUNNING);

        if (clear_eff) begin
            state_n = IDLE;
            presc_n = '0;
            count_n = '0;
            hold_n  = 1'b0;
            ovf_n   = 1'b0;
        end else begin
            if (state == RUNNING) begin
                if (presc == PRESC_LAST) begin
                    presc_n = '0;
                    tick_n  = 1'b1;
                    count_n = count_inc;
                    if (count_wrap) begin
                        ovf_n = 1'b1;
                    end
                end else begin
                    presc_n = presc + DIV_W'(1);
                end
            end
            if (start_stop) begin
                case (state)
                    IDLE:    state_n = RUNNING;
                    RUNNING: state_n = PAUSED;
                    PAUSED:  state_n = RUNNING;
                    default: state_n = IDLE;
                endcase
            end else if (lap) begin
                if (state == RUNNING) begin
                    hold_n = ~lap_hold;
                end else if (state == PAUSED && lap_hold) begin
                    hold_n = 1'b0;
                end
            end
        end

        // Freeze the display while held; capture the new count on the 0->1 edge
        if (hold_n && lap_hold) begin
            disp_n = disp_bcd;
        end else begin
            disp_n = count_n;
        end
        running_n = (state_n == RUNNING);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            presc    <= '0;
            count    <= '0;
            disp_bcd <= '0;
            running  <= 1'b0;
            lap_hold <= 1'b0;
            overflow <= 1'b0;
            cs_tick  <= 1'b0;
        end else begin
            state    <= state_n;
            presc    <= presc_n;
            count    <= count_n;
            disp_bcd <= disp_n;
            running  <= running_n;
            lap_hold <= hold_n;
            overflow <= ovf_n;
            cs_tick  <= tick_n;
        end
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// Randomized and directed bench for stopwatch_core against an integer
// centisecond reference model.
module tb_stopwatch_core;

    localparam int unsigned TD    = 4;
    localparam int unsigned MAXM  = 1;
    localparam int          TOTAL = (MAXM + 1) * 6000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_stop = 1'b0;
    logic        lap = 1'b0;
    logic        clear = 1'b0;
    logic [23:0] disp_bcd;
    logic        running;
    logic        lap_hold;
    logic        overflow;
    logic        cs_tick;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0 idle, 1 running, 2 paused; count in centiseconds
    int m_mode  = 0;
    int m_presc = 0;
    int m_cnt   = 0;
    int m_latch = 0;
    int m_hold  = 0;
    int m_ovf   = 0;
    int m_tick  = 0;

    stopwatch_core #(
        .TICK_DIV (TD),
        .DIV_W    (3),
        .MAX_MIN  (MAXM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .disp_bcd   (disp_bcd),
        .running    (running),
        .lap_hold   (lap_hold),
        .overflow   (overflow),
        .cs_tick    (cs_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int cs);
        int m, s, c;
        m = cs / 6000;
        s = (cs / 100) % 60;
        c = cs % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic model_step(input logic r, input logic ss, input logic lp, input logic cl);
        if (r) begin
            m_mode = 0; m_presc = 0; m_cnt = 0; m_hold = 0; m_ovf = 0; m_tick = 0; m_latch = 0;
        end else if (cl && m_mode != 1) begin
            m_mode = 0; m_presc = 0; m_cnt = 0; m_hold = 0; m_ovf = 0; m_tick = 0;
        end else begin
            m_tick = 0;
            if (m_mode == 1) begin
                m_presc = (m_presc + 1) % TD;
                if (m_presc == 0) begin
                    m_tick = 1;
                    m_cnt  = m_cnt + 1;
                    if (m_cnt == TOTAL) begin
                        m_cnt = 0;
                        m_ovf = 1;
                    end
                end
            end
            if (ss) begin
                m_mode = (m_mode == 1) ? 2 : 1;
            end else if (lp) begin
                if (m_mode == 1) begin
                    m_hold = 1 - m_hold;
                    if (m_hold == 1) m_latch = m_cnt;
                end else if (m_mode == 2 && m_hold == 1) begin
                    m_hold = 0;
                end
            end
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare away from the edge
    task automatic cycle(input logic r, input logic ss, input logic lp, input logic cl);
        rst = r; start_stop = ss; lap = lp; clear = cl;
        @(posedge clk);
        model_step(r, ss, lp, cl);
        #1;
        check("disp_bcd", 32'(disp_bcd), 32'(to_bcd(m_hold ? m_latch : m_cnt)));
        check("running",  32'(running),  32'(m_mode == 1));
        check("lap_hold", 32'(lap_hold), 32'(m_hold));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("cs_tick",  32'(cs_tick),  32'(m_tick));
        rst = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    endtask

    task automatic run_until_count(input int target, input int budget);
        int n;
        n = 0;
        while (m_cnt != target && n < budget) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        check("reach_count", 32'(m_cnt), 32'(target));
    endtask

    initial begin
        // Reset and first run
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("reset_disp", 32'(disp_bcd), 32'h0);
        check("reset_run",  32'(running),  32'h0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("start_run", 32'(running), 32'h1);
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("disp_40cyc", 32'(disp_bcd), 32'h000010);

        // Pause retains prescaler phase
        run_until_count(50, 400);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("paused_disp", 32'(disp_bcd), 32'h000050);
        check("paused_run",  32'(running),  32'h0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        run_until_count(51, 10);
        check("resume_disp", 32'(disp_bcd), 32'h000051);

        // Lap hold and release
        run_until_count(100, 400);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("lap_on", 32'(lap_hold), 32'h1);
        run_until_count(119, 200);
        check("lap_frozen", 32'(disp_bcd), 32'h000100);
        run_until_count(120, 10);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("lap_release", 32'(disp_bcd), 32'h000120);

        // Overflow wrap, then pause + clear
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        run_until_count(TOTAL - 1, TD * TOTAL + 16);
        check("max_disp", 32'(disp_bcd), 32'h015999);
        run_until_count(0, 8);
        check("wrap_disp", 32'(disp_bcd), 32'h000000);
        check("wrap_ovf",  32'(overflow), 32'h1);
        check("wrap_run",  32'(running),  32'h1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("clear_ovf", 32'(overflow), 32'h0);

        // Clear ignored while running; clear beats start_stop when paused
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        run_until_count(3, 40);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("clear_running", 32'(running), 32'h1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check("clear_ss_run",  32'(running),  32'h0);
        check("clear_ss_disp", 32'(disp_bcd), 32'h0);

        // Reset mid-run
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        run_until_count(37, 400);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_mid_disp", 32'(disp_bcd), 32'h0);
        check("rst_mid_run",  32'(running),  32'h0);
        check("rst_mid_tick", 32'(cs_tick),  32'h0);

        // Random control traffic
        for (int i = 0; i < 6000; i++) begin
            cycle(($urandom_range(0, 499) == 0),
                  ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 14) == 0),
                  ($urandom_range(0, 29) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
